// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - MSB-first UART receiver with receive FIFO and MMIO status window
module uart_rx_mmio #(
  parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFF0,
  parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFF3,
  parameter int          CLKS_PER_BIT = 6,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  input  logic        uart_rx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus decode
  logic in_range;
  logic ctrl_wr;
  logic pop_req;
  logic clr_req;

  assign in_range = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
  assign ctrl_wr  = memWrite && byteMask[3] && in_range;
  assign pop_req  = ctrl_wr && memWriteData[24];
  assign clr_req  = ctrl_wr && memWriteData[25];

  // Only the control lane carries meaning on writes; the remaining bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{memWriteData[31:26], memWriteData[23:0], byteMask[2:0]};

  // Input synchroniser
  logic sync1;
  logic rxs;

  // Two-flop synchroniser, idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Receiver state
  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          stop_tick;

  assign stop_tick = (state == S_STOP) && (bit_cnt == '0);

  // Receiver FSM: mid-bit sampling driven by a down-counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            bit_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (bit_cnt == '0) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
              bit_cnt <= FULL_LOAD;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_cnt == '0) begin
            shift_reg <= {shift_reg[6:0], rxs};
            bit_cnt   <= FULL_LOAD;
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          if (bit_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO and flags
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overrun;
  logic          frame_err;
  logic          full;
  logic          empty;
  logic          pop_do;
  logic          push_do;
  logic          overrun_set;
  logic          frame_set;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
  assign pop_do      = pop_req && !empty;
  assign push_do     = stop_tick && rxs && (!full || pop_do);
  assign overrun_set = stop_tick && rxs && full && !pop_do;
  assign frame_set   = stop_tick && !rxs;

  // FIFO storage: the head is masked by empty, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_do) begin
      fifo_mem[wr_ptr] <= shift_reg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_do) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_do) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_do, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun   && !clr_req) || overrun_set;
      frame_err <= (frame_err && !clr_req) || frame_set;
    end
  end

  // Register read
  logic [7:0]  rx_data;
  logic [7:0]  count_b;
  logic [7:0]  status;
  logic [31:0] rd_q;
  logic        rd_drive;

  assign rx_data = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign count_b = 8'(count);
  assign status  = {3'b000, (state != S_IDLE), frame_err, overrun, full, !empty};

  // Registered read word; out-of-range cycles release the bus on the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q     <= '0;
      rd_drive <= 1'b1;
    end else begin
      rd_drive <= in_range;
      rd_q     <= in_range ? {8'h00, rx_data, count_b, status} : 32'h0000_0000;
    end
  end

  assign memReadData = rd_drive ? rd_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - scoreboard bench for uart_rx_mmio with a queue-based reference model
module tb_uart_rx_mmio;

  localparam int          CPB       = 6;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE      = 32'hFFFF_FFF0;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_1000;
  localparam logic [31:0] POP       = 32'h0100_0000;
  localparam logic [31:0] CLR       = 32'h0200_0000;
  // Two synchroniser edges, one edge for IDLE to act, half a bit to the
  // start sample, then nine bit periods to the stop sample.
  localparam int          STOP_EDGE = 2 + 1 + CPB / 2 + 9 * CPB;

  logic        clk;
  logic        reset;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;
  logic        uart_rx;

  uart_rx_mmio #(
    .BASE_MEMORY (BASE),
    .TOP_MEMORY  (BASE + 32'd3),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memWrite    (memWrite),
    .byteMask    (byteMask),
    .memReadData (memReadData),
    .uart_rx     (uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: received bytes in arrival order plus the two sticky flags
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_live = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [7:0] head;
    logic [7:0] st;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    st   = {3'b000, 1'b0, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    return {8'h00, head, 8'(mq.size()), st};
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)                m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                         mq.push_back(b);
  endtask

  task automatic model_pop();
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic model_clear();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Issue a one-cycle in-range read; the monitor checks the registered result
  task automatic bus_read(input string nm, input logic [31:0] exp);
    memAddress = BASE + 32'($urandom_range(0, 3));
    memWrite   = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    rd_live = 1'b1;
    @(negedge clk);
    rd_live    = 1'b0;
    memAddress = IDLE_ADDR;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    memAddress   = addr;
    memWriteData = data;
    byteMask     = mask;
    memWrite     = 1'b1;
    @(negedge clk);
    memWrite     = 1'b0;
    byteMask     = 4'h0;
    memWriteData = 32'h0;
    memAddress   = IDLE_ADDR;
  endtask

  task automatic ctrl(input logic [31:0] data);
    bus_write(BASE + 32'($urandom_range(0, 3)), data, 4'b1000);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Monitor: on each edge that captures a bench read, compare against the queue head
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      if (rd_live) begin
        #1;
        if (exp_q.size() == 0) begin
          check("sb_underflow", memReadData, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, memReadData, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         r;

    reset        = 1'b0;
    uart_rx      = 1'b1;
    memAddress   = IDLE_ADDR;
    memWriteData = 32'h0;
    memWrite     = 1'b0;
    byteMask     = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_value", memReadData, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus_read("post_reset", model_word());

    // Single frame then pop
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
    bus_read("a5_read", 32'h00A5_0101);
    ctrl(POP); model_pop();
    bus_read("a5_popped", 32'h0000_0000);

    // Fill past capacity, drain in order, clear overrun
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i * 8'h11);
      send_frame(b, 1'b1); model_frame(b, 1'b1);
    end
    bus_read("five_full", 32'h0011_0407);
    for (int i = 0; i < 4; i++) begin
      bus_read("drain", model_word());
      ctrl(POP); model_pop();
    end
    bus_read("drain_empty", 32'h0000_0004);
    ctrl(CLR); model_clear();
    bus_read("ovr_cleared", 32'h0000_0000);

    // Framing error, then a good frame
    send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    bus_read("frame_err", 32'h0000_0008);
    ctrl(CLR); model_clear();
    send_frame(8'h7E, 1'b1); model_frame(8'h7E, 1'b1);
    bus_read("after_ferr", 32'h007E_0101);
    ctrl(POP); model_pop();

    // Short low glitch: busy briefly, nothing stored
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    bus_read("glitch_busy", 32'h0000_0010);
    repeat (10) @(negedge clk);
    bus_read("glitch_idle", 32'h0000_0000);

    // Full FIFO with a pop landing on the stop-sample edge of the next frame
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1); model_frame(b, 1'b1);
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(negedge clk);
        ctrl(POP);
      end
    join
    model_pop(); model_frame(8'h99, 1'b1);
    bus_read("pop_on_stop", model_word());
    for (int i = 0; i < 4; i++) begin
      bus_read("pop_on_stop_drain", model_word());
      ctrl(POP); model_pop();
    end
    bus_read("pop_on_stop_empty", 32'h0000_0000);

    // Reset in the middle of a frame with a byte already buffered
    send_frame(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_frame", memReadData, 32'h0);
      end
    join
    mq.delete(); model_clear();
    check("reset_held", memReadData, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus_read("after_reset", 32'h0000_0000);
    send_frame(8'h0F, 1'b1); model_frame(8'h0F, 1'b1);
    bus_read("after_reset_frame", 32'h000F_0101);
    ctrl(POP); model_pop();

    // Randomized mix of frames, pops, clears and writes that must be ignored
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        b  = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 7) != 0);
        send_frame(b, ok); model_frame(b, ok);
      end else if (r <= 6) begin
        ctrl(POP); model_pop();
      end else if (r == 7) begin
        ctrl(CLR); model_clear();
      end else if (r == 8) begin
        bus_write(BASE, POP | CLR, 4'b0111);
      end else begin
        bus_write(BASE - 32'd4, POP | CLR, 4'b1111);
      end
      bus_read("random", model_word());
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver that feeds the SoC's serial-input path. It deserialises `uart_rx` frames produced by the same-format transmitter, so the bit order is MSB-first. Received bytes are buffered in a small FIFO, and the FIFO head, occupancy and status are exposed on the shared 32-bit MMIO bus with a registered read.

## Interface
- `BASE_MEMORY`, default 32'hFFFF_FFF0, first byte address of the 4-byte register window.
- `TOP_MEMORY`, default 32'hFFFF_FFF3, last byte address of the window.
- `CLKS_PER_BIT`, default 6, clk cycles per bit. 6 matches a transmitter baud divider of 3. Must be ≥4 and even.
- `FIFO_DEPTH`, default 4, number of receive FIFO entries. Power of two, 2–16.
- `clk` input 1 — system clock; all logic is on its rising edge.
- `reset` input 1 — asynchronous, active-low. 0 forces the reset state immediately.
- `memAddress` input 32 — bus byte address.
- `memWriteData` input 32 — bus write data.
- `memWrite` input 1 — write strobe.
- `byteMask` input 4 — write byte-lane enables.
- `memReadData` output 32 — registered read data.
- `uart_rx` input 1 — asynchronous serial input; idles high.

## Operation
- Register lanes of the aligned word:
  - [31:24] control, write-only, reads 0.
  - [23:16] rx_data, read-only: the FIFO head, or 0 when empty.
  - [15:8] count, read-only: FIFO occupancy, 0..FIFO_DEPTH.
  - [7:0] status, read-only: bit0 valid (count≠0), bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky), bit4 busy (receiver not IDLE), bits 7:5 = 0.
- Control write actions require memWrite, byteMask[3] and an in-range address:
  - Bit0 = pop: discard the FIFO head. Ignored when the FIFO is empty.
  - Bit1 = clear both sticky flags.
  - These are actions only; nothing is stored.
- Read path:
  - Address in range: memReadData is loaded every cycle with {8'h00, rx_data, count, status}, sampled before that edge's updates.
  - Address out of range: memReadData is loaded with 32'hzzzz_zzzz.
- Input synchroniser: `uart_rx` passes through a 2-flop synchroniser whose flops reset to 1. The receiver sees only the synchronised value, `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rxs=0, go to START and load the bit counter with CLKS_PER_BIT/2 − 1.
  - START: at counter 0 (mid start bit), sample rxs. If 1, it was a glitch: return to IDLE with no flag set. If 0, go to DATA, set bit index to 0 and reload the counter with CLKS_PER_BIT − 1.
  - DATA: at each counter 0, shift in rxs MSB-first (first sample becomes shift[7]) and reload the counter. After the 8th sample, go to STOP.
  - STOP: at counter 0, sample rxs, then return to IDLE.
    - rxs=1 and FIFO not full: push the byte.
    - rxs=1 and FIFO full: drop the byte and set overrun.
    - rxs=0: drop the byte and set frame_err.
- FIFO: circular buffer with read pointer, write pointer and a count register of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect and count is unchanged. With the FIFO full, the pop frees the slot, so the push succeeds with no overrun.
  - Clear and a new error in the same cycle: the flag ends up set.

## Timing
- Reset values:
  - memReadData = 0, FSM in IDLE, counters = 0, FIFO empty, pointers = 0.
  - overrun = 0, frame_err = 0, synchroniser flops = 1, shift register = 0.
- Latency from the `uart_rx` falling edge:
  - IDLE sees rxs=0 two clk edges later.
  - The start-bit sample is CLKS_PER_BIT/2 cycles after that.
  - Data sample k (k=0..7) is (k+1)·CLKS_PER_BIT cycles after the start-bit sample.
  - The stop-bit sample is 9·CLKS_PER_BIT cycles after the start-bit sample.
  - The push happens on the stop-sample edge, and count/valid update on that same edge.
- Bus timing: an in-range read presented in cycle N appears on memReadData after edge N+1, one cycle of latency. A pop in cycle N is reflected in a read issued in cycle N+1.
- FSM re-arm: the FSM reaches IDLE on the stop-sample edge and can detect the next start bit in the next cycle. Back-to-back frames are therefore received.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied and the FSM returns to IDLE. After release, the line must be seen high before a falling edge counts as a start bit; a line held low is treated as a start bit.

## Test plan
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 MSB-first, stop=1), CLKS_PER_BIT=6 -> read returns rx_data=0xA5, count=1, status=0x01. After pop: count=0, rx_data=0x00, status=0x00.
- Five frames 0x11, 0x22, 0x33, 0x44, 0x55 with no pop -> count=4, status=0x07. Successive pops read 0x11, 0x22, 0x33, 0x44. Clear -> status=0x00.
- Frame 0x3C with stop bit 0 -> count=0, status=0x08. The next good frame 0x7E is received with count=1.
- 2-cycle low glitch on idle `uart_rx` -> busy pulses, then returns to 0. count stays 0 and no flags are set.
- FIFO full plus a pop issued on the exact stop-sample cycle of a fifth frame 0x99 -> count stays 4, overrun=0, and 0x99 is the last entry.
- Assert reset low in the middle of DATA of frame 0xF0 -> memReadData=0, count=0, busy=0. After release, frame 0x0F is received intact.
